mem_wb_stage: RTL
=================

Name: mem_wb_stage

Overview:
- Combined memory-access and writeback stage of the 64-bit RISC-V pipeline.
- Accepts one executed instruction per handshake.
- For loads and stores, performs a single data-bus transaction. For loads, aligns and extends the returned data.
- Drives the register file write port (wvalid/wa/wd) from a registered writeback slot.
- Reports per-instruction commit (and misalignment) to the difftest/commit logic.

Parameters:
- XLEN, 64, datapath width; fixed at 64.
- RADDR_W, 5, register address width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept an instruction this cycle.
- in_pc  in  64  instruction PC.
- in_rd  in  5  destination register.
- in_wen  in  1  instruction writes rd.
- in_alu  in  64  ALU result; this is the effective address for memory ops.
- in_memread  in  1  load.
- in_memwrite  in  1  store; never set together with in_memread.
- in_size  in  2  access size: 0=byte, 1=half, 2=word, 3=double.
- in_unsigned  in  1  zero-extend load (LBU/LHU/LWU).
- in_sdata  in  64  store data, in the low bytes.
- dreq_valid  out  1  data request pending.
- dreq_addr  out  64  request address, equal to in_alu.
- dreq_write  out  1  request is a store.
- dreq_strobe  out  8  byte write enables; 0 for loads.
- dreq_data  out  64  lane-aligned store data.
- dresp_valid  in  1  response or acknowledge for the pending request.
- dresp_data  in  64  8-byte-aligned load data.
- wvalid  out  1  register file write enable.
- wa  out  5  register file write address.
- wd  out  64  register file write data.
- commit_valid  out  1  instruction retired this cycle.
- commit_pc  out  64  PC of the retired instruction.
- commit_misalign  out  1  retired instruction was a misaligned memory op.

Behaviour:
- Reset, asynchronous, any state:
  - state=IDLE; all outputs 0 except in_ready=1.
  - Any pending request is abandoned and no writeback occurs.
  - After reset deassertion, a dresp_valid for the abandoned request is ignored because the state is IDLE.
- FSM has two states, IDLE and WAIT.
- in_ready = (state==IDLE). An instruction is accepted at a clock edge where in_valid&&in_ready.
- Misalignment:
  - misaligned = memory op && (in_alu mod (1<<in_size)) != 0.
  - No request is issued for a misaligned op; it is handled like a non-memory op with wvalid=0 and commit_misalign=1.
- Non-memory op, or misaligned op, accepted at edge N:
  - The writeback slot is loaded and the state stays IDLE.
  - In cycle N+1: commit_valid=1, commit_pc=in_pc, wvalid=in_wen&&(in_rd!=0), wa=in_rd, wd=in_alu.
  - Back-to-back throughput is 1 instruction per cycle.
- Memory op accepted at edge N:
  - Transitions to WAIT and latches the request fields.
  - From cycle N+1, dreq_valid=1 with dreq_addr/dreq_write/dreq_strobe/dreq_data stable until the response.
  - In WAIT, dresp_valid low: stay in WAIT.
  - In WAIT, dresp_valid high at edge M: state goes to IDLE and the writeback slot is loaded. In cycle M+1: commit_valid=1, dreq_valid=0, in_ready=1.
  - Minimum latency is accept to commit = 2 cycles.
- Store encoding (off=in_alu[2:0]):
  - dreq_strobe = ((1<<(1<<in_size))-1) << off.
  - dreq_data = in_sdata << (8*off).
  - Stores never write the register file.
- Load data: shifted = dresp_data >> (8*off), truncated to 8/16/32/64 bits by in_size.
  - in_unsigned=1: zero-extend. Otherwise sign-extend from the top bit of the access.
  - in_unsigned is ignored for size 3.
  - wd = extended value; wvalid = in_wen&&(in_rd!=0).
- rd==0: wvalid is always 0, but commit_valid is still asserted.
- Writeback slot outputs are valid for exactly one cycle per instruction; there is no backpressure from the register file.
- A dresp_valid while in IDLE is ignored.

Test Plan:
- Reset mid-WAIT:
  - Stimulus: accept load to 0x1000, assert reset in cycle N+2, deassert, then pulse dresp_valid.
  - Response: no wvalid, no commit_valid; in_ready=1; dreq_valid=0 during and after reset.
- Back-to-back non-memory ops:
  - Stimulus: three ALU ops on consecutive cycles, rd=5/6/0, in_alu=0x11/0x22/0x33.
  - Response: wvalid=1,1,0 in cycles N+1..N+3 with wd=0x11, 0x22; commit_valid=1 on all three cycles.
- Signed and unsigned byte loads:
  - Stimulus: load byte at addr 0x1003 with dresp_data=0x0000_0000_8000_0000, rd=7, after a 3-cycle response delay.
  - Response: signed load gives wd=0xFFFF_FFFF_FFFF_FF80; unsigned load gives wd=0x80. Both commit 4 cycles after accept, and in_ready=0 throughout WAIT.
- Halfword store:
  - Stimulus: store half at addr 0x2006, in_sdata=0xABCD.
  - Response: dreq_strobe=0xC0, dreq_data=0xABCD_0000_0000_0000, dreq_write=1; wvalid stays 0; commit_valid=1 one cycle after dresp_valid.
- Misaligned access:
  - Stimulus: word load at addr 0x3002.
  - Response: dreq_valid never asserted; next cycle commit_valid=1, commit_misalign=1, wvalid=0.
- Doubleword load plus stray response:
  - Stimulus: doubleword load at addr 0x4000 returning 0x0123_4567_89AB_CDEF, then a dresp_valid pulse while IDLE.
  - Response: wd=0x0123_4567_89AB_CDEF; the stray response causes no state change and no second commit.

Source files
------------

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ===========================================================================
// mem_wb_stage: RV64 memory-access + writeback stage, one bus transaction per load/store.
// Revision: 1.0
// ===========================================================================
module mem_wb_stage #(
   parameter int XLEN    = 64,
   parameter int RADDR_W = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [XLEN-1:0]    in_pc,
   input  logic [RADDR_W-1:0] in_rd,
   input  logic               in_wen,
   input  logic [XLEN-1:0]    in_alu,
   input  logic               in_memread,
   input  logic               in_memwrite,
   input  logic [1:0]         in_size,
   input  logic               in_unsigned,
   input  logic [XLEN-1:0]    in_sdata,
   output logic               dreq_valid,
   output logic [XLEN-1:0]    dreq_addr,
   output logic               dreq_write,
   output logic [7:0]         dreq_strobe,
   output logic [XLEN-1:0]    dreq_data,
   input  logic               dresp_valid,
   input  logic [XLEN-1:0]    dresp_data,
   output logic               wvalid,
   output logic [RADDR_W-1:0] wa,
   output logic [XLEN-1:0]    wd,
   output logic               commit_valid,
   output logic [XLEN-1:0]    commit_pc,
   output logic               commit_misalign
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   state_t r_state, w_next_state;

   logic               w_accept;
   logic               w_memop;
   logic               w_misalign;
   logic [2:0]         w_off;
   logic [7:0]         w_strobe_base;
   logic [XLEN-1:0]    w_shifted;
   logic [XLEN-1:0]    w_load;

   logic [2:0]         r_off;
   logic [1:0]         r_size;
   logic               r_unsigned;
   logic [RADDR_W-1:0] r_rd;
   logic               r_wen;
   logic [XLEN-1:0]    r_pc;

   assign in_ready   = (r_state == S_IDLE);
   assign dreq_valid = (r_state == S_WAIT);
   assign w_accept   = in_valid && in_ready;
   assign w_memop    = in_memread || in_memwrite;
   assign w_off      = in_alu[2:0];

   always_comb begin
      w_misalign    = 1'b0;
      w_strobe_base = 8'h01;
      case (in_size)
         2'd0: begin w_misalign = 1'b0;          w_strobe_base = 8'h01; end
         2'd1: begin w_misalign = in_alu[0];     w_strobe_base = 8'h03; end
         2'd2: begin w_misalign = |in_alu[1:0];  w_strobe_base = 8'h0F; end
         default: begin w_misalign = |in_alu[2:0]; w_strobe_base = 8'hFF; end
      endcase
      w_misalign = w_misalign && w_memop;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (w_accept && w_memop && !w_misalign) w_next_state = S_WAIT;
         S_WAIT:  if (dresp_valid) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Response is 8-byte aligned; move the addressed bytes down before extending.
   assign w_shifted = dresp_data >> {r_off, 3'b000};

   always_comb begin
      w_load = w_shifted;
      case (r_size)
         2'd0: w_load = {{(XLEN-8){!r_unsigned && w_shifted[7]}},   w_shifted[7:0]};
         2'd1: w_load = {{(XLEN-16){!r_unsigned && w_shifted[15]}}, w_shifted[15:0]};
         2'd2: w_load = {{(XLEN-32){!r_unsigned && w_shifted[31]}}, w_shifted[31:0]};
         default: w_load = w_shifted;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dreq_addr       <= '0;
         dreq_write      <= 1'b0;
         dreq_strobe     <= 8'h00;
         dreq_data       <= '0;
         r_off           <= 3'd0;
         r_size          <= 2'd0;
         r_unsigned      <= 1'b0;
         r_rd            <= '0;
         r_wen           <= 1'b0;
         r_pc            <= '0;
         wvalid          <= 1'b0;
         wa              <= '0;
         wd              <= '0;
         commit_valid    <= 1'b0;
         commit_pc       <= '0;
         commit_misalign <= 1'b0;
      end else begin
         wvalid          <= 1'b0;
         commit_valid    <= 1'b0;
         commit_misalign <= 1'b0;
         if (w_accept) begin
            if (w_memop && !w_misalign) begin
               dreq_addr   <= in_alu;
               dreq_write  <= in_memwrite;
               dreq_strobe <= in_memwrite ? (w_strobe_base << w_off) : 8'h00;
               dreq_data   <= in_memwrite ? (in_sdata << {w_off, 3'b000}) : '0;
               r_off       <= w_off;
               r_size      <= in_size;
               r_unsigned  <= in_unsigned;
               r_rd        <= in_rd;
               r_wen       <= in_wen;
               r_pc        <= in_pc;
            end else begin
               commit_valid    <= 1'b1;
               commit_pc       <= in_pc;
               commit_misalign <= w_misalign;
               wvalid          <= in_wen && (|in_rd) && !w_memop;
               wa              <= in_rd;
               wd              <= in_alu;
            end
         end else if ((r_state == S_WAIT) && dresp_valid) begin
            commit_valid <= 1'b1;
            commit_pc    <= r_pc;
            wvalid       <= r_wen && (|r_rd) && !dreq_write;
            wa           <= r_rd;
            wd           <= w_load;
         end
      end
   end

endmodule
`default_nettype wire
